// File: rtl/asi_pkg.sv
// rtl/asi_pkg.sv - shared types and constants for the ASI memory arbiter
package asi_pkg;
   localparam int DEF_AXI_AW = 32;
   localparam int DEF_AXI_DW = 64;
   localparam int DEF_MEM_AW = 12;
   localparam int SLV_BYTEW_LOG = $clog2(DEF_AXI_DW / 8);

   typedef enum logic [1:0] {ARB_IDLE, ARB_W, ARB_R} arb_state_t;
   typedef enum logic {OWN_W, OWN_R} arb_owner_t;

   function automatic int bytew_log(input int dw);
      return $clog2(dw / 8);
   endfunction
endpackage

// File: rtl/asi_rd_pipe.sv
// rtl/asi_rd_pipe.sv - read return delay line tracking valid and dropped beats
module asi_rd_pipe #(
   parameter int RD_LAT = 1,
   parameter int DW     = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          drop,
   input  logic [DW-1:0] mem_rdata,
   output logic          rvalid,
   output logic [DW-1:0] rdata
);
   logic [RD_LAT-1:0] v_q;
   logic [RD_LAT-1:0] d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         v_q[0] <= push;
         d_q[0] <= push & drop;
         for (int i = 1; i < RD_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
         end
      end
   end

   // Dropped beats still return a valid slot so the requester's beat count holds.
   assign rvalid = v_q[RD_LAT-1];
   assign rdata  = (rvalid && !d_q[RD_LAT-1]) ? mem_rdata : '0;
endmodule

// File: rtl/asi_mem_arb.sv
// rtl/asi_mem_arb.sv - round-robin burst arbiter between write and read sides for one SRAM port
module asi_mem_arb
   import asi_pkg::*;
#(
   parameter int AXI_AW = DEF_AXI_AW,
   parameter int AXI_DW = DEF_AXI_DW,
   parameter int MEM_AW = DEF_MEM_AW,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                w_req,
   output logic                w_gnt,
   input  logic                w_we,
   input  logic [AXI_AW-1:0]   w_addr,
   input  logic [AXI_DW-1:0]   w_data,
   input  logic [AXI_DW/8-1:0] w_strb,
   input  logic                w_last,
   input  logic                r_req,
   output logic                r_gnt,
   input  logic                r_re,
   input  logic [AXI_AW-1:0]   r_addr,
   input  logic                r_last,
   output logic                r_rvalid,
   output logic [AXI_DW-1:0]   r_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [AXI_DW/8-1:0] mem_be,
   output logic [AXI_DW-1:0]   mem_wdata,
   input  logic [AXI_DW-1:0]   mem_rdata,
   output logic                err
);
   localparam int BL = bytew_log(AXI_DW);

   arb_state_t state, next_state;
   arb_owner_t last_owner;
   logic w_beat, r_beat, w_done, r_done, w_ok, r_ok, proto_err, range_err;

   assign w_beat    = w_we & w_gnt;
   assign r_beat    = r_re & r_gnt;
   assign w_done    = w_beat & w_last;
   assign r_done    = r_beat & r_last;
   assign w_ok      = (w_addr >> (MEM_AW + BL)) == '0;
   assign r_ok      = (r_addr >> (MEM_AW + BL)) == '0;
   assign proto_err = (w_we & ~w_gnt) | (r_re & ~r_gnt);
   assign range_err = (w_beat & ~w_ok) | (r_beat & ~r_ok);

   // Grants are registered from next_state so a burst handover has no idle cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         last_owner <= OWN_R;
         w_gnt      <= 1'b0;
         r_gnt      <= 1'b0;
         err        <= 1'b0;
      end else begin
         state <= next_state;
         w_gnt <= (next_state == ARB_W);
         r_gnt <= (next_state == ARB_R);
         err   <= err | proto_err | range_err;
         if (w_done)      last_owner <= OWN_W;
         else if (r_done) last_owner <= OWN_R;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ARB_IDLE: begin
            if (w_req && r_req) next_state = (last_owner == OWN_R) ? ARB_W : ARB_R;
            else if (w_req)     next_state = ARB_W;
            else if (r_req)     next_state = ARB_R;
         end
         ARB_W: begin
            if (w_done)      next_state = r_req ? ARB_R : (w_req ? ARB_W : ARB_IDLE);
            else if (!w_req) next_state = ARB_IDLE;
         end
         ARB_R: begin
            if (r_done)      next_state = w_req ? ARB_W : (r_req ? ARB_R : ARB_IDLE);
            else if (!r_req) next_state = ARB_IDLE;
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      if (w_beat && w_ok) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = w_addr[BL +: MEM_AW];
         mem_be    = w_strb;
         mem_wdata = w_data;
      end else if (r_beat && r_ok) begin
         mem_en   = 1'b1;
         mem_addr = r_addr[BL +: MEM_AW];
         mem_be   = '1;
      end
   end

   asi_rd_pipe #(
      .RD_LAT(RD_LAT),
      .DW    (AXI_DW)
   ) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (r_beat),
      .drop     (~r_ok),
      .mem_rdata(mem_rdata),
      .rvalid   (r_rvalid),
      .rdata    (r_rdata)
   );
endmodule

// File: tb/tb_asi_mem_arb.sv
// tb/tb_asi_mem_arb.sv - directed self-checking bench for asi_mem_arb
module tb_asi_mem_arb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        w_req, w_gnt, w_we, w_last;
   logic [31:0] w_addr;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        r_req, r_gnt, r_re, r_last, r_rvalid;
   logic [31:0] r_addr;
   logic [63:0] r_rdata;
   logic        mem_en, mem_we, err;
   logic [11:0] mem_addr;
   logic [7:0]  mem_be;
   logic [63:0] mem_wdata, mem_rdata, sram_s1;
   int total = 0;
   int bad = 0;

   asi_mem_arb #(.AXI_AW(32), .AXI_DW(64), .MEM_AW(12), .RD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .w_req(w_req), .w_gnt(w_gnt), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .w_strb(w_strb), .w_last(w_last),
      .r_req(r_req), .r_gnt(r_gnt), .r_re(r_re), .r_addr(r_addr), .r_last(r_last),
      .r_rvalid(r_rvalid), .r_rdata(r_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input logic [11:0] a);
      return {20'hA5A5A, a, 20'h5A5A5, a};
   endfunction

   // Two-cycle SRAM read model with fixed contents per word address.
   always @(posedge clk) begin
      if (mem_en && !mem_we) sram_s1 <= pat(mem_addr);
      mem_rdata <= sram_s1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; w_req = 1'b1; r_req = 1'b1;
      w_we = 1'b0; w_last = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
      r_re = 1'b0; r_last = 1'b0; r_addr = '0;
      tick();
      check("rst_w_gnt", w_gnt, 0);
      check("rst_r_gnt", r_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_err", err, 0);
      check("rst_rvalid", r_rvalid, 0);

      rst_n = 1'b1;
      #1 check("tie_pre_gnt", w_gnt, 0);
      tick();
      check("tie_w_gnt", w_gnt, 1);
      check("tie_r_gnt", r_gnt, 0);

      for (int k = 0; k < 4; k++) begin
         w_we = 1'b1; w_addr = 32'h40 + 32'(8 * k); w_data = 64'h1111_0000_0000_0000 + 64'(k);
         w_strb = 8'hFF; w_last = (k == 3);
         if (k == 3) w_req = 1'b0;
         #1;
         check("wr_en", mem_en, 1);
         check("wr_we", mem_we, 1);
         check("wr_addr", mem_addr, 64'(8 + k));
         check("wr_data", mem_wdata, 64'h1111_0000_0000_0000 + 64'(k));
         tick();
      end
      w_we = 1'b0; w_last = 1'b0;
      check("handover_r_gnt", r_gnt, 1);
      check("handover_w_gnt", w_gnt, 0);

      for (int c = 0; c < 6; c++) begin
         if (c < 3) begin
            r_re = 1'b1; r_addr = 32'h100 + 32'(8 * c); r_last = (c == 2);
            if (c == 2) r_req = 1'b0;
         end else begin
            r_re = 1'b0; r_last = 1'b0;
         end
         #1;
         if (c < 3) begin
            check("rd_addr", mem_addr, 64'(12'h20 + c));
            check("rd_en", mem_en, 1);
            check("rd_we", mem_we, 0);
            check("rd_be", mem_be, 8'hFF);
         end
         check("rd_rvalid", r_rvalid, (c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) check("rd_rdata", r_rdata, pat(12'(32'h20 + c - 2)));
         tick();
      end
      check("rd_idle_gnt", r_gnt, 0);

      w_req = 1'b1;
      tick();
      check("narrow_gnt", w_gnt, 1);
      w_we = 1'b1; w_strb = 8'h0F; w_addr = 32'h7; w_data = 64'hDEAD_BEEF_0123_4567; w_last = 1'b1;
      #1;
      check("narrow_be", mem_be, 8'h0F);
      check("narrow_addr", mem_addr, 0);
      check("narrow_en", mem_en, 1);
      tick();
      w_we = 1'b0; w_last = 1'b0;
      check("narrow_hold_gnt", w_gnt, 1);
      check("narrow_err", err, 0);

      w_we = 1'b1; w_addr = 32'h8000; w_strb = 8'hFF;
      #1;
      check("range_en", mem_en, 0);
      check("range_err_pre", err, 0);
      tick();
      w_we = 1'b0;
      check("range_err", err, 1);
      tick();
      tick();
      check("range_err_sticky", err, 1);

      r_req = 1'b1;
      for (int k = 0; k < 2; k++) begin
         w_we = 1'b1; w_addr = 32'h200 + 32'(8 * k);
         tick();
      end
      w_we = 1'b1; w_addr = 32'h210; rst_n = 1'b0;
      #1;
      check("mid_rst_en", mem_en, 0);
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_wdata", mem_wdata, 0);
      check("mid_rst_w_gnt", w_gnt, 0);
      check("mid_rst_err", err, 0);
      tick();
      w_we = 1'b0; rst_n = 1'b1;
      tick();
      check("post_rst_w_gnt", w_gnt, 1);
      check("post_rst_r_gnt", r_gnt, 0);

      r_re = 1'b1; r_addr = 32'h100;
      #1;
      check("proto_en", mem_en, 0);
      tick();
      r_re = 1'b0;
      check("proto_err", err, 1);

      w_req = 1'b0; r_req = 1'b0;
      tick();
      check("drop_w_gnt", w_gnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/asi_mem_arb.md
Name: asi_mem_arb

Overview:
- Arbitrates a single-port SRAM between the write-side slave interface and the read-side slave interface, both in the user clock domain.
- Grants whole bursts using round-robin priority.
- Maps byte addresses to memory word addresses and drives the SRAM control, address, data and byte enables.
- Returns read data to the read side with a fixed, parameterised latency.

Parameters:
AXI_AW, 32, byte address width of both requesters
AXI_DW, 64, data width; strobe width is AXI_DW/8
MEM_AW, 12, SRAM word address width
RD_LAT, 1, SRAM read latency in cycles (1..4)

Ports:
clk  in  1  user clock
rst_n  in  1  asynchronous, active-low reset
w_req  in  1  write side busy/request (level)
w_gnt  out  1  write side granted
w_we  in  1  write beat strobe; legal only while w_gnt=1
w_addr  in  AXI_AW  write beat byte address
w_data  in  AXI_DW  write beat data
w_strb  in  AXI_DW/8  write beat strobes
w_last  in  1  last write beat of burst
r_req  in  1  read side request (level)
r_gnt  out  1  read side granted
r_re  in  1  read beat strobe; legal only while r_gnt=1
r_addr  in  AXI_AW  read beat byte address
r_last  in  1  last read beat of burst
r_rvalid  out  1  read data valid
r_rdata  out  AXI_DW  read data
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  MEM_AW  SRAM word address
mem_be  out  AXI_DW/8  SRAM byte enables
mem_wdata  out  AXI_DW  SRAM write data
mem_rdata  in  AXI_DW  SRAM read data, valid RD_LAT cycles after a read enable
err  out  1  sticky protocol/range error

Behaviour:
- Reset values:
  - state=ARB_IDLE; last_owner=READ, so write wins the first tie.
  - All outputs 0; read delay line cleared.
  - Reset mid-burst drops the burst with no memory access.
- States:
  - ARB_IDLE: w_gnt=r_gnt=0.
    - Both requesting: go to the side that is not last_owner.
    - One requesting: go to that side.
    - Neither: stay.
  - ARB_W: w_gnt=1 (registered, asserted the cycle after entry).
  - ARB_R: r_gnt=1 (registered, asserted the cycle after entry).
- Burst lock: the owner keeps the grant until its last beat is accepted (w_we&w_last or r_re&r_last). On that cycle, in priority order:
  - Other side requesting: go directly to the other grant state (zero idle cycles).
  - Else owner's req still high: stay.
  - Else: go to ARB_IDLE.
  - last_owner updates on every last beat.
- Request drop: if the owner's req falls without a last beat, go to ARB_IDLE the next cycle.
- Beat acceptance is combinational, same cycle:
  - mem_en = (w_we&w_gnt) | (r_re&r_gnt), gated by the range check.
  - mem_we = w_we&w_gnt.
  - mem_be = w_strb on a write, all ones on a read.
  - mem_wdata = w_data.
  - mem_addr = addr[SLV_BYTEW_LOG +: MEM_AW] of the granted side; low byte-lane bits are ignored.
- Range check: address bits above MEM_AW+SLV_BYTEW_LOG nonzero → beat dropped (mem_en=0) and err set.
  - A dropped read still produces r_rvalid with r_rdata=0, so the beat count is preserved.
- Protocol error: w_we while w_gnt=0, or r_re while r_gnt=0 → beat ignored and err set. err clears only on reset.
- Read return:
  - A valid shift line of depth RD_LAT; r_rvalid asserts exactly RD_LAT cycles after the accepted r_re.
  - r_rdata = mem_rdata, or 0 for a dropped beat.
  - Back-to-back reads give back-to-back r_rvalid.
- Pipeline drain: no flush on a grant switch. In-flight reads complete while writes proceed (SRAM read data is captured independent of a later write).
- Simultaneous requests rising in the same cycle while in ARB_IDLE are resolved by last_owner only.

Decomposition:
- asi_pkg additions:
  - typedef enum logic [1:0] ARB_STATE {ARB_IDLE, ARB_W, ARB_R}
  - typedef enum logic ARB_OWNER {OWN_W, OWN_R}
  - localparam SLV_BYTEW_LOG = $clog2(AXI_DW/8)
- One sub-module: asi_rd_pipe, the RD_LAT-deep valid/drop delay line with async reset.

Test Plan:
- Tie resolution: w_req=r_req=1 from reset → w_gnt=1 at cycle 2. A 4-beat write at addr 0x40 gives mem_addr 8,9,10,11 with mem_we=1. On the last beat the next cycle shows r_gnt=1, w_gnt=0.
- Read latency: RD_LAT=2, read burst of 3 beats at 0x100 → mem_addr 0x20..0x22. r_rvalid high exactly cycles t+2..t+4, with r_rdata matching the SRAM model.
- Narrow write: w_strb=8'h0F, w_addr=0x7 → mem_be=8'h0F, mem_addr=0.
- Range error: MEM_AW=12, w_addr=0x8000 → mem_en=0 and err=1 from the next cycle, staying 1 until reset.
- Protocol error: r_re pulsed while w_gnt=1 → no mem_en for the read, err=1.
- Reset mid-burst: rst_n low during beat 2 of 8 → all outputs 0 immediately. After release, state is ARB_IDLE and the first tie goes to write.
